// File: rtl/ram_arbitrated_if.sv
// Request/grant bus between CH requesters and the shared RAM.
// Per-channel fields are packed side by side, channel i at [i*width +: width].
interface ram_arbitrated_if #(
  parameter int A  = 10,
  parameter int D  = 8,
  parameter int CH = 2
);
  localparam int W = D / 8;

  logic [CH-1:0]   req;
  logic [CH-1:0]   we;
  logic [CH*W-1:0] be;
  logic [CH*A-1:0] addr;
  logic [CH*D-1:0] din;
  logic [CH-1:0]   gnt;
  logic [CH-1:0]   rvalid;
  logic [D-1:0]    rdata;

  modport master (
    output req, we, be, addr, din,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, be, addr, din,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/ram_arbitrated.sv
// Single-port RAM shared by CH requesters through a round-robin arbiter,
// with byte-lane writes, registered reads and a zero-fill clear sequencer.
module ram_arbitrated #(
  parameter int A  = 10,
  parameter int D  = 8,
  parameter int CH = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic busy,
  ram_arbitrated_if.slave bus
);
  localparam int W     = D / 8;
  localparam int DEPTH = 1 << A;
  localparam int PW    = (CH > 1) ? $clog2(CH) : 1;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t state, state_n;

  logic [A-1:0]  cnt;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] idx;
  logic          found;
  logic          grant;
  logic          rd;
  logic [CH-1:0] gnt_c;
  logic [CH-1:0] rv_n;
  logic [A-1:0]  sel_addr;
  logic [D-1:0]  sel_din;
  logic [W-1:0]  sel_be;
  logic          sel_we;
  logic [A-1:0]  waddr;
  logic [D-1:0]  wdata;
  logic [W-1:0]  lane_we;

  logic [D-1:0] mem [DEPTH];

  // first requester at or after ptr, wrapping mod CH
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int j = 0; j < CH; j++) begin
      idx = PW'((int'(ptr) + j) % CH);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign grant    = (state == IDLE) && !clr && found;
  assign sel_addr = bus.addr[win*A +: A];
  assign sel_din  = bus.din[win*D +: D];
  assign sel_be   = bus.be[win*W +: W];
  assign sel_we   = bus.we[win];
  assign rd       = grant && !sel_we;

  always_comb begin
    gnt_c = '0;
    rv_n  = '0;
    if (grant) gnt_c[win] = 1'b1;
    if (rd) rv_n[win] = 1'b1;
  end

  assign bus.gnt = gnt_c;
  assign busy    = (state == CLEAR);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (clr) state_n = CLEAR;
      CLEAR: if (cnt == A'(DEPTH - 1)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt        <= '0;
      ptr        <= '0;
      bus.rvalid <= '0;
      bus.rdata  <= '0;
    end else begin
      bus.rvalid <= rv_n;
      if (state == CLEAR) cnt <= cnt + 1'b1;
      if (grant) ptr <= PW'((int'(win) + 1) % CH);
      if (rd) bus.rdata <= mem[sel_addr];
    end
  end

  // a reset edge suppresses every write, so an aborted clear stops cleanly
  always_comb begin
    waddr = (state == CLEAR) ? cnt : sel_addr;
    wdata = (state == CLEAR) ? '0 : sel_din;
    for (int k = 0; k < W; k++) begin
      lane_we[k] = reset_n &&
        ((state == CLEAR) || (grant && sel_we && sel_be[k]));
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < W; k++) begin
      if (lane_we[k]) mem[waddr][k*8 +: 8] <= wdata[k*8 +: 8];
    end
  end
endmodule

// File: tb/tb_ram_arbitrated.sv
// Directed bench for ram_arbitrated (A=10, D=16, CH=2).
// Expected values are hand-computed constants.
module tb_ram_arbitrated;
  localparam int A  = 10;
  localparam int D  = 16;
  localparam int CH = 2;
  localparam int W  = D / 8;

  logic clk;
  logic reset_n;
  logic clr;
  logic busy;

  int checks;
  int errors;
  int n;
  int gbad;

  ram_arbitrated_if #(.A(A), .D(D), .CH(CH)) bus ();

  ram_arbitrated #(.A(A), .D(D), .CH(CH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .busy    (busy),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic w, input logic [W-1:0] b,
                        input logic [A-1:0] a, input logic [D-1:0] d);
    bus.req[ch]        = 1'b1;
    bus.we[ch]         = w;
    bus.be[ch*W +: W]  = b;
    bus.addr[ch*A +: A] = a;
    bus.din[ch*D +: D] = d;
  endtask

  task automatic do_write(input string tag, input int ch, input logic [A-1:0] a,
                          input logic [D-1:0] d, input logic [W-1:0] b);
    bus.req = '0;
    set_ch(ch, 1'b1, b, a, d);
    #1;
    check({tag, "_gnt"}, 32'(bus.gnt), 32'(1 << ch));
    step();
    check({tag, "_rv"}, 32'(bus.rvalid), 32'h0);
    bus.req = '0;
  endtask

  task automatic do_read(input string tag, input int ch, input logic [A-1:0] a,
                         input logic [D-1:0] exp);
    bus.req = '0;
    set_ch(ch, 1'b0, '0, a, '0);
    #1;
    check({tag, "_gnt"}, 32'(bus.gnt), 32'(1 << ch));
    step();
    check({tag, "_rv"}, 32'(bus.rvalid), 32'(1 << ch));
    check({tag, "_rd"}, 32'(bus.rdata), 32'(exp));
    bus.req = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    clr     = 1'b0;
    reset_n = 1'b0;
    bus.req  = '0;
    bus.we   = '0;
    bus.be   = '0;
    bus.addr = '0;
    bus.din  = '0;
    do_reset();
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rv", 32'(bus.rvalid), 32'h0);
    check("rst_rd", 32'(bus.rdata), 32'h0);

    // write then read back
    do_write("t1_wr", 0, 10'h010, 16'h00A5, 2'b11);
    do_read("t1_rd", 0, 10'h010, 16'h00A5);
    step();
    check("t1_rv_idle", 32'(bus.rvalid), 32'h0);
    check("t1_rd_hold", 32'(bus.rdata), 32'h00A5);

    // round-robin with both channels reading
    do_write("t2_pre", 1, 10'h020, 16'h5A5A, 2'b11);
    do_reset();
    set_ch(0, 1'b0, '0, 10'h010, '0);
    set_ch(1, 1'b0, '0, 10'h020, '0);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t2_gnt", 32'(bus.gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
      step();
      check("t2_rv", 32'(bus.rvalid), (k % 2 == 0) ? 32'h1 : 32'h2);
      check("t2_rd", 32'(bus.rdata), (k % 2 == 0) ? 32'h00A5 : 32'h5A5A);
    end
    bus.req = '0;

    // byte-lane write merge
    do_write("t3_w1", 0, 10'h030, 16'h1234, 2'b11);
    do_write("t3_w2", 0, 10'h030, 16'hABCD, 2'b10);
    do_write("t3_w3", 1, 10'h030, 16'hFFFF, 2'b00);
    do_read("t3_rd", 1, 10'h030, 16'hAB34);

    // full clear, requests held throughout
    do_write("t4_pre", 1, 10'h3FF, 16'h7777, 2'b11);
    set_ch(0, 1'b0, '0, 10'h010, '0);
    set_ch(1, 1'b0, '0, 10'h020, '0);
    clr = 1'b1;
    #1;
    check("t4_clr_gnt", 32'(bus.gnt), 32'h0);
    check("t4_clr_busy", 32'(busy), 32'h0);
    step();
    clr  = 1'b0;
    n    = 0;
    gbad = 0;
    while (busy && n < 2000) begin
      if (bus.gnt != '0 || bus.rvalid != '0) gbad++;
      n++;
      step();
    end
    check("t4_len", 32'(n), 32'd1024);
    check("t4_quiet", 32'(gbad), 32'h0);
    check("t4_resume", 32'(|bus.gnt), 32'h1);
    bus.req = '0;
    do_read("t4_rd", 0, 10'h3FF, 16'h0000);

    // reset aborts a clear after 100 words
    do_write("t5_p0", 0, 10'h000, 16'h1111, 2'b11);
    do_write("t5_p1", 0, 10'h063, 16'h2222, 2'b11);
    do_write("t5_p2", 0, 10'h064, 16'hBEEF, 2'b11);
    clr = 1'b1;
    #1;
    step();
    clr = 1'b0;
    repeat (100) step();
    check("t5_busy_on", 32'(busy), 32'h1);
    reset_n = 1'b0;
    step();
    check("t5_busy_off", 32'(busy), 32'h0);
    reset_n = 1'b1;
    do_read("t5_r0", 0, 10'h000, 16'h0000);
    do_read("t5_r63", 0, 10'h063, 16'h0000);
    do_read("t5_r64", 0, 10'h064, 16'hBEEF);

    // reset lands on an outstanding read
    do_write("t6_wr", 0, 10'h010, 16'h00A5, 2'b11);
    set_ch(0, 1'b0, '0, 10'h010, '0);
    #1;
    check("t6_gnt", 32'(bus.gnt), 32'h1);
    reset_n = 1'b0;
    step();
    check("t6_rv", 32'(bus.rvalid), 32'h0);
    check("t6_rd", 32'(bus.rdata), 32'h0);
    reset_n = 1'b1;
    set_ch(1, 1'b0, '0, 10'h020, '0);
    #1;
    check("t6_ptr", 32'(bus.gnt), 32'h1);
    step();
    check("t6_rv2", 32'(bus.rvalid), 32'h1);
    check("t6_rd2", 32'(bus.rdata), 32'h00A5);
    bus.req = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
